// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-logic stage: object codes
// handed to the VGA controller, move directions, FSM states and grid geometry.
package snake_pkg;

    typedef enum logic [1:0] {
        OBJ_NONE = 2'b00,
        OBJ_HEAD = 2'b01,
        OBJ_BODY = 2'b10,
        OBJ_WALL = 2'b11
    } object_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;

    // Grid cell: 6-bit column, 5-bit row
    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
    } cell_t;

    localparam logic [5:0] START_X = 6'd20;
    localparam logic [4:0] START_Y = 5'd15;
    localparam logic [5:0] X_LAST  = 6'(GRID_W - 1);
    localparam logic [4:0] Y_LAST  = 5'(GRID_H - 1);

    function automatic dir_e opposite_dir(input dir_e d);
        dir_e r;
        r = DIR_LEFT;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

    // Key_dir is {up,down,left,right}; up has the highest priority
    function automatic dir_e key_to_dir(input logic [3:0] key);
        dir_e r;
        if (key[3])      r = DIR_UP;
        else if (key[2]) r = DIR_DOWN;
        else if (key[1]) r = DIR_LEFT;
        else             r = DIR_RIGHT;
        return r;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running move-step divider: counts enabled cycles 0..STEP_DIV-1 and
// raises tick_o on the last one. Holds its count while disabled.
module step_timer #(
    parameter int STEP_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o = en_i && (count_q == LAST);

    // Advance only while enabled; wrap to zero on the tick cycle
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = tick_o ? '0 : count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake game logic: segment array, run/pause/over FSM, move/grow/collision on
// each step tick, and a registered per-pixel classifier feeding the VGA stage.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 12_500_000
) (
    input  logic       Clk_25mhz,
    input  logic       Rst,
    input  logic       Game_en,
    input  logic [3:0] Key_dir,
    input  logic [9:0] Pixel_x,
    input  logic [9:0] Pixel_y,
    input  logic [5:0] Apple_x,
    input  logic [4:0] Apple_y,
    output logic [1:0] Object,
    output logic       Apple_eaten,
    output logic       Game_over,
    output logic [5:0] Length
);

    state_e  state_q, state_d;
    logic    run_en;
    logic    game_over;
    logic    step;

    dir_e    dir_q, dir_d;
    dir_e    pending_q, pending_d;
    dir_e    key_dir;

    cell_t   seg_q [MAX_LEN];
    cell_t   next_cell;
    cell_t   pix_cell;

    logic [5:0] len_q, len_d;
    logic       eaten_q;
    object_e    obj_q, obj_d;

    logic [MAX_LEN-1:0] self_hit;
    logic [MAX_LEN-1:0] pix_hit;
    logic border_hit, collision, move, apple_hit;
    logic pix_blank, pix_wall;

    // Initial body lies straight to the left of the start head
    function automatic cell_t reset_cell(input int idx);
        cell_t c;
        c = '0;
        if (idx < INIT_LEN) begin
            c.x = START_X - 6'(idx);
            c.y = START_Y;
        end
        return c;
    endfunction

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk_i  (Clk_25mhz),
        .rst_i  (Rst),
        .en_i   (run_en),
        .tick_o (step)
    );

    // FSM state register
    always_ff @(posedge Clk_25mhz) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: collision outranks a pause request on the same step
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Game_en) state_d = ST_RUN;
            ST_RUN: begin
                if (step && collision) state_d = ST_OVER;
                else if (!Game_en)     state_d = ST_IDLE;
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: timer runs only in RUN with the enable still asserted
    always_comb begin
        run_en    = (state_q == ST_RUN) && Game_en;
        game_over = (state_q == ST_OVER);
    end

    // Candidate head cell for this step; the pending direction is what moves
    always_comb begin
        next_cell = seg_q[0];
        case (pending_q)
            DIR_UP:   next_cell.y = seg_q[0].y - 5'd1;
            DIR_DOWN: next_cell.y = seg_q[0].y + 5'd1;
            DIR_LEFT: next_cell.x = seg_q[0].x - 6'd1;
            default:  next_cell.x = seg_q[0].x + 6'd1;
        endcase
    end

    // Per-segment comparators against the next head and the current pixel cell.
    // The last live segment is excluded from self-collision because it vacates.
    genvar gi;
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
        if (gi == 0) begin : g_head
            assign self_hit[gi] = 1'b0;
        end else begin : g_body
            assign self_hit[gi] = (6'(gi) + 6'd2 <= len_q) && (seg_q[gi] == next_cell);
        end
        assign pix_hit[gi] = (6'(gi) < len_q) && (seg_q[gi] == pix_cell);
    end

    assign border_hit = (next_cell.x == 6'd0) || (next_cell.x == X_LAST) ||
                        (next_cell.y == 5'd0) || (next_cell.y == Y_LAST);
    assign collision  = border_hit || (|self_hit);
    assign move       = step && !collision;
    assign apple_hit  = (next_cell.x == Apple_x) && (next_cell.y == Apple_y);

    // Direction latch: a key may not reverse the direction in force after this edge
    always_comb begin
        dir_d     = step ? pending_q : dir_q;
        key_dir   = key_to_dir(Key_dir);
        pending_d = pending_q;
        if ((Key_dir != 4'd0) && (key_dir != opposite_dir(dir_d))) begin
            pending_d = key_dir;
        end
    end

    // Growth saturates at MAX_LEN; the shift keeps the old tail as new last segment
    always_comb begin
        len_d = len_q;
        if (move && apple_hit && (len_q < 6'(MAX_LEN))) begin
            len_d = len_q + 6'd1;
        end
    end

    // Pixel classification: HEAD > BODY > WALL > NONE, blanking forces NONE
    assign pix_blank = (Pixel_x >= 10'(H_ACTIVE)) || (Pixel_y >= 10'(V_ACTIVE));
    assign pix_cell  = {Pixel_x[9:CELL_SHIFT], Pixel_y[CELL_SHIFT+4:CELL_SHIFT]};
    assign pix_wall  = (pix_cell.x == 6'd0) || (pix_cell.x == X_LAST) ||
                       (pix_cell.y == 5'd0) || (pix_cell.y == Y_LAST);

    // Object code for the pixel presented this cycle
    always_comb begin
        obj_d = OBJ_NONE;
        if (!pix_blank) begin
            if (pix_hit[0])                  obj_d = OBJ_HEAD;
            else if (|pix_hit[MAX_LEN-1:1])  obj_d = OBJ_BODY;
            else if (pix_wall)               obj_d = OBJ_WALL;
        end
    end

    // Segment shift register: head takes the new cell, each segment follows
    always_ff @(posedge Clk_25mhz) begin
        if (Rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_q[i] <= reset_cell(i);
            end
        end else if (move) begin
            seg_q[0] <= next_cell;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_q[i] <= seg_q[i-1];
            end
        end
    end

    // Direction, length, apple pulse and object registers
    always_ff @(posedge Clk_25mhz) begin
        if (Rst) begin
            dir_q     <= DIR_RIGHT;
            pending_q <= DIR_RIGHT;
            len_q     <= 6'(INIT_LEN);
            eaten_q   <= 1'b0;
            obj_q     <= OBJ_NONE;
        end else begin
            dir_q     <= dir_d;
            pending_q <= pending_d;
            len_q     <= len_d;
            eaten_q   <= move && apple_hit;
            obj_q     <= obj_d;
        end
    end

    assign Object      = obj_q;
    assign Apple_eaten = eaten_q;
    assign Game_over   = game_over;
    assign Length      = len_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: directed game scenarios plus random
// play, all checked cycle by cycle against a queue-based snake model.
module tb_snake_body_ctrl;

    localparam int STEP_DIV = 4;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;

    logic       Clk_25mhz = 1'b0;
    logic       Rst;
    logic       Game_en;
    logic [3:0] Key_dir;
    logic [9:0] Pixel_x;
    logic [9:0] Pixel_y;
    logic [5:0] Apple_x;
    logic [4:0] Apple_y;
    logic [1:0] Object;
    logic       Apple_eaten;
    logic       Game_over;
    logic [5:0] Length;

    snake_body_ctrl #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .Clk_25mhz   (Clk_25mhz),
        .Rst         (Rst),
        .Game_en     (Game_en),
        .Key_dir     (Key_dir),
        .Pixel_x     (Pixel_x),
        .Pixel_y     (Pixel_y),
        .Apple_x     (Apple_x),
        .Apple_y     (Apple_y),
        .Object      (Object),
        .Apple_eaten (Apple_eaten),
        .Game_over   (Game_over),
        .Length      (Length)
    );

    always #20 Clk_25mhz = ~Clk_25mhz;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Snake kept as a queue of cells, head first. Directions: 0 up 1 down 2 left 3 right.
    // Game phases: 0 idle, 1 running, 2 over.
    int snake_x[$];
    int snake_y[$];
    int m_phase, m_timer, m_dir, m_pend, m_steps;
    int last_tail_x, last_tail_y;

    function automatic int dx(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int key_pick(input logic [3:0] k);
        if (k[3]) return 0;
        if (k[2]) return 1;
        if (k[1]) return 2;
        return 3;
    endfunction

    function automatic int reverse_of(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void model_reset();
        snake_x.delete();
        snake_y.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            snake_x.push_back(20 - i);
            snake_y.push_back(15);
        end
        m_phase = 0;
        m_timer = 0;
        m_dir   = 3;
        m_pend  = 3;
        last_tail_x = 17;
        last_tail_y = 15;
    endfunction

    function automatic int classify(input int px, input int py);
        int cx, cy;
        if (px >= 640 || py >= 480) return 0;
        cx = px / 16;
        cy = py / 16;
        if (snake_x[0] == cx && snake_y[0] == cy) return 1;
        for (int i = 1; i < snake_x.size(); i++)
            if (snake_x[i] == cx && snake_y[i] == cy) return 2;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
        return 0;
    endfunction

    // One clock: predict from current inputs, advance the model, then compare
    task automatic cycle();
        int ex_obj, ex_eat, nx, ny;
        bit active, stepped, hit;
        ex_eat = 0;
        if (Rst) begin
            model_reset();
            ex_obj = 0;
        end else begin
            ex_obj  = classify(int'(Pixel_x), int'(Pixel_y));
            active  = (m_phase == 1) && Game_en;
            stepped = active && (m_timer == STEP_DIV - 1);
            if (m_phase == 0 && Game_en) m_phase = 1;
            else if (m_phase == 1 && !Game_en) m_phase = 0;
            if (active) m_timer = (m_timer + 1) % STEP_DIV;
            if (stepped) begin
                m_steps++;
                m_dir = m_pend;
                nx = snake_x[0] + dx(m_dir);
                ny = snake_y[0] + dy(m_dir);
                hit = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
                for (int i = 1; i <= snake_x.size() - 2; i++)
                    if (snake_x[i] == nx && snake_y[i] == ny) hit = 1;
                if (hit) begin
                    m_phase = 2;
                end else begin
                    snake_x.push_front(nx);
                    snake_y.push_front(ny);
                    if (nx == int'(Apple_x) && ny == int'(Apple_y)) begin
                        ex_eat = 1;
                        if (snake_x.size() > MAX_LEN) begin
                            last_tail_x = snake_x.pop_back();
                            last_tail_y = snake_y.pop_back();
                        end
                    end else begin
                        last_tail_x = snake_x.pop_back();
                        last_tail_y = snake_y.pop_back();
                    end
                end
            end
            if (Key_dir != 4'd0 && key_pick(Key_dir) != reverse_of(m_dir))
                m_pend = key_pick(Key_dir);
        end
        @(posedge Clk_25mhz);
        #1;
        check("object", 32'(Object), ex_obj);
        check("apple_eaten", 32'(Apple_eaten), ex_eat);
        check("game_over", 32'(Game_over), (m_phase == 2) ? 1 : 0);
        check("length", 32'(Length), snake_x.size());
    endtask

    // ---------------- directed helpers ----------------
    task automatic run_steps(input int n, output int cyc);
        int target;
        target = m_steps + n;
        cyc = 0;
        while (m_steps < target && cyc < 40 * n) begin
            cycle();
            cyc++;
        end
        check("step_budget", m_steps, target);
    endtask

    task automatic steps(input int n);
        int unused_cyc;
        run_steps(n, unused_cyc);
    endtask

    task automatic probe(input int px, input int py, input int exp_obj, input string tag);
        Pixel_x = 10'(px);
        Pixel_y = 10'(py);
        cycle();
        check(tag, 32'(Object), exp_obj);
    endtask

    task automatic turn(input logic [3:0] k);
        Key_dir = k;
        cycle();
        Key_dir = 4'd0;
        steps(1);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
    endtask

    initial begin
        int cyc, guard, r, idx, nx, ny;
        m_steps = 0;
        Rst = 1'b1; Game_en = 1'b0; Key_dir = 4'd0;
        Pixel_x = 10'd0; Pixel_y = 10'd0; Apple_x = 6'd5; Apple_y = 5'd5;

        // Reset values
        cycle();
        check("rst_length", 32'(Length), 3);
        check("rst_object", 32'(Object), 0);
        check("rst_over", 32'(Game_over), 0);
        check("rst_eaten", 32'(Apple_eaten), 0);
        $display("scenario reset: Length=%0d Object=%0d", Length, Object);

        // Straight run, pixel classes
        Rst = 1'b0; Game_en = 1'b1;
        steps(1);
        probe(336, 240, 1, "head_21_15");
        probe(320, 240, 2, "body_20_15");
        probe(0, 0, 3, "wall_0_0");
        steps(1);
        probe(352, 240, 1, "head_22_15");
        Key_dir = 4'b0010;
        cycle();
        Key_dir = 4'd0;
        steps(1);
        probe(368, 240, 1, "left_ignored_23_15");
        turn(4'b1000);
        probe(368, 224, 1, "up_23_14");
        $display("scenario straight/turn: head probed at (23,14)");

        // Apple growth and length-5 U-turn self collision
        do_reset();
        Apple_x = 6'd21; Apple_y = 5'd15;
        steps(1);
        check("eat_pulse", 32'(Apple_eaten), 1);
        check("eat_len4", 32'(Length), 4);
        Apple_x = 6'd5; Apple_y = 5'd5;
        probe(288, 240, 2, "old_tail_body");
        check("eat_one_cycle", 32'(Apple_eaten), 0);
        Apple_x = 6'd22; Apple_y = 5'd15;
        steps(1);
        check("eat_len5", 32'(Length), 5);
        Apple_x = 6'd5; Apple_y = 5'd5;
        turn(4'b1000);
        turn(4'b0010);
        turn(4'b0100);
        check("self_hit_over", 32'(Game_over), 1);
        for (int i = 0; i < 8; i++) cycle();
        probe(336, 224, 1, "frozen_head_21_14");
        check("self_hit_len", 32'(Length), 5);
        $display("scenario self collision: Game_over=%0d Length=%0d", Game_over, Length);

        // Reset out of OVER
        do_reset();
        check("rst_from_over", 32'(Game_over), 0);
        check("rst_from_over_len", 32'(Length), 3);

        // Tail chase with length 4, then into the right wall
        Apple_x = 6'd21; Apple_y = 5'd15;
        steps(1);
        Apple_x = 6'd5; Apple_y = 5'd5;
        turn(4'b1000);
        turn(4'b0010);
        turn(4'b0100);
        check("tail_chase_ok", 32'(Game_over), 0);
        probe(320, 240, 1, "tail_chase_head");
        turn(4'b0001);
        guard = 0;
        while (m_phase != 2 && guard < 300) begin
            cycle();
            guard++;
        end
        check("wall_over", 32'(Game_over), 1);
        probe(608, 240, 1, "wall_head_38_15");
        for (int i = 0; i < 8; i++) cycle();
        probe(608, 240, 1, "wall_head_frozen");
        check("wall_len", 32'(Length), 4);
        probe(700, 100, 0, "blank_x");
        probe(100, 500, 0, "blank_y");
        $display("scenario wall: Game_over=%0d", Game_over);

        // Pause mid-count keeps the timer
        do_reset();
        Game_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        Game_en = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        Game_en = 1'b1;
        run_steps(1, cyc);
        check("pause_resume_cycles", cyc, 3);
        probe(336, 240, 1, "pause_head_21_15");
        $display("scenario pause: step after %0d cycles", cyc);

        // Random play
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                Game_en = ($urandom_range(0, 19) != 0);
                Rst = ($urandom_range(0, 499) == 0);
                Key_dir = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                r = int'($urandom_range(0, 9));
                if (r < 5) begin
                    idx = int'($urandom_range(0, snake_x.size() - 1));
                    Pixel_x = 10'(snake_x[idx] * 16 + int'($urandom_range(0, 15)));
                    Pixel_y = 10'(snake_y[idx] * 16 + int'($urandom_range(0, 15)));
                end else if (r == 5) begin
                    Pixel_x = 10'(last_tail_x * 16 + int'($urandom_range(0, 15)));
                    Pixel_y = 10'(last_tail_y * 16 + int'($urandom_range(0, 15)));
                end else if (r == 6) begin
                    Pixel_x = 10'($urandom_range(600, 1023));
                    Pixel_y = 10'($urandom_range(440, 1023));
                end else begin
                    Pixel_x = 10'($urandom_range(0, 639));
                    Pixel_y = 10'($urandom_range(0, 479));
                end
                if ($urandom_range(0, 3) == 0) begin
                    nx = snake_x[0] + dx(m_pend);
                    ny = snake_y[0] + dy(m_pend);
                    if (nx >= 1 && nx <= 38 && ny >= 1 && ny <= 28) begin
                        Apple_x = 6'(nx);
                        Apple_y = 5'(ny);
                    end else begin
                        Apple_x = 6'($urandom_range(1, 38));
                        Apple_y = 5'($urandom_range(1, 28));
                    end
                end
                cycle();
            end
            Rst = 1'b0;
        end
        $display("scenario random: %0d model steps total", m_steps);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
